bram_window_ctrl: RTL and testbench
===================================

# bram_window_ctrl

Sequencing controller for the image-window datapath's dual-port BRAM (8-bit write port A, 32-bit read port B). On `Start` it loads a byte stream into the BRAM through port A, then reads it back one 32-bit word at a time through port B. Each new word is shifted into a two-word register pair, and byte-lane steering is stepped across the pair for the downstream window/steer logic. It owns the BRAM for the whole operation, indicates this with `LOCK`, and pulses `Complete` at the end.

## Interface
- `LOAD_BYTES`, 2048: bytes loaded per run; must be a multiple of 4, at least 8 and at most 2048.
- `ADDRA_W`, 11: port A address width.
- `ADDRB_W`, 9: port B address width.
- Derived constant: `NUM_WORDS` = `LOAD_BYTES`/4.

Ports:
- `CLK`  in  1  sole clock, rising edge.
- `Reset`  in  1  synchronous, active-low reset.
- `Start`  in  1  run request; sampled only in IDLE.
- `din`  in  8  load byte.
- `din_valid`  in  1  `din` valid.
- `din_ready`  out  1  controller accepts `din`.
- `EN_A`  out  1  port A enable.
- `W_A`  out  1  port A write enable.
- `Addra`  out  `ADDRA_W`  port A byte address.
- `dina`  out  8  port A write data.
- `EN_B`  out  1  port B read enable.
- `Addrb`  out  `ADDRB_W`  port B word address.
- `db`  in  32  port B read data; valid one cycle after `EN_B`.
- `register1`  out  32  newest word read.
- `register2`  out  32  previous word.
- `En_Steer`  out  1  steering window valid.
- `Select`  out  3  byte offset into {`register2`,`register1`}, 0..3.
- `LOCK`  out  1  BRAM owned by this controller.
- `Complete`  out  1  one-cycle end-of-run pulse.

## Operation
- States: IDLE, LOAD, READ, CAPT, STEER, DONE.
- **IDLE**
  - `Start`=1 moves to LOAD; the byte counter and word counter are cleared.
- **LOAD**
  - `din_ready`=1.
  - Accepted beat: `din_valid`&`din_ready`.
  - On each accepted beat, combinationally: `EN_A`=`W_A`=1, `dina`=`din`, `Addra`=byte counter. The counter then increments.
  - No beat means `EN_A`=`W_A`=0.
  - After the beat at address `LOAD_BYTES`-1 is accepted, go to READ.
- **READ**
  - `EN_B`=1, `Addrb`=word counter, for one cycle; go to CAPT.
- **CAPT**
  - `register2`<=`register1`, `register1`<=`db`.
  - If word counter = 0 (priming): increment it and go to READ.
  - Otherwise go to STEER with `Select`=0.
- **STEER**
  - Lasts 4 cycles with `En_Steer`=1 and `Select`=0,1,2,3.
  - After `Select`=3: if word counter = `NUM_WORDS`-1, go to DONE; otherwise increment it and go to READ.
- **DONE**
  - `Complete`=1 for one cycle, then IDLE.
- Output qualification:
  - `LOCK`=1 in every state except IDLE.
  - `En_Steer`=0 and `Select`=0 outside STEER.
  - `EN_B`=0 outside READ.
  - `din_ready`=0 outside LOAD.
- Byte order within a word is little-endian: byte k of word w is BRAM byte 4w+k.
- `Start` is ignored outside IDLE. `Start` held high through DONE starts a new run on the first IDLE cycle.
- `register1`/`register2` hold their values between runs and are cleared only by reset.

## Timing
- Reset (`Reset`=0 at a rising edge) forces IDLE and clears both counters. Every output reads 0, including `register1` and `register2`.
- Mid-operation reset has the same effect; BRAM contents are left as they were.
- `Start` at cycle 0 gives LOAD from cycle 1.
- With continuous `din_valid`, LOAD lasts `LOAD_BYTES` cycles.
- After the last load beat the read phase lasts 2 + 6·(`NUM_WORDS`-1) cycles, followed by DONE (1 cycle).
- `Complete` and the `LOCK` falling edge occur in the same cycle as leaving DONE; `LOCK`=0 from the next cycle.
- Counters never wrap: the byte counter stops at `LOAD_BYTES`-1 and the word counter at `NUM_WORDS`-1.

## Test plan
- **Reset:** assert `Reset`=0 for 2 cycles with random inputs → all outputs 0 and `LOCK`=0; `Start` during reset is ignored.
- **Full run:** `LOAD_BYTES`=16, `din`=0x00..0x0F continuous, with a BRAM model.
  - `Addra` steps 0..15 in cycles 1–16 with `dina`=`Addra`.
  - `Addrb` = 0,1,2,3 in cycles 17, 19, 25, 31.
  - At the first STEER (cycle 21): `register1`=0x07060504, `register2`=0x03020100, `Select` 0..3 over cycles 21–24.
  - `Complete`=1 in cycle 37 only.
- **Gapped input:** `din_valid` every other cycle → `EN_A` only on accepted beats, `Addra` has no gaps, LOAD lasts 32 cycles, read phase timing unchanged.
- **Start handling:** `Start` pulsed mid-LOAD and mid-STEER → no effect. `Start` held high through DONE → LOAD starts on the cycle after IDLE with `Addra`=0.
- **Reset mid-operation:** `Reset`=0 during STEER (`Select`=2) → next cycle all outputs 0; a new `Start` loads from `Addra`=0.
- **Minimum size:** `LOAD_BYTES`=8 → exactly one STEER block (4 cycles); `Complete` 9 cycles after the last load beat.

Source files
------------

// File: rtl/bram_window_ctrl.sv
// BRAM window sequencer: byte-wide load on port A, word readback on port B,
// two-word register pair with byte-lane steering for the window logic.
module bram_window_ctrl #(
  parameter int LOAD_BYTES = 2048,
  parameter int ADDRA_W    = 11,
  parameter int ADDRB_W    = 9
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               Start,
  input  logic [7:0]         din,
  input  logic               din_valid,
  output logic               din_ready,
  output logic               EN_A,
  output logic               W_A,
  output logic [ADDRA_W-1:0] Addra,
  output logic [7:0]         dina,
  output logic               EN_B,
  output logic [ADDRB_W-1:0] Addrb,
  input  logic [31:0]        db,
  output logic [31:0]        register1,
  output logic [31:0]        register2,
  output logic               En_Steer,
  output logic [2:0]         Select,
  output logic               LOCK,
  output logic               Complete
);

  localparam int NUM_WORDS = LOAD_BYTES / 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_READ,
    S_CAPT,
    S_STEER,
    S_DONE
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [ADDRA_W-1:0] byte_cnt;
  logic [ADDRB_W-1:0] word_cnt;
  logic [1:0]         sel_cnt;
  logic               last_byte;
  logic               last_word;

  assign last_byte = (byte_cnt == ADDRA_W'(LOAD_BYTES - 1));
  assign last_word = (word_cnt == ADDRB_W'(NUM_WORDS - 1));

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state     <= S_IDLE;
      byte_cnt  <= '0;
      word_cnt  <= '0;
      sel_cnt   <= '0;
      register1 <= '0;
      register2 <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        S_IDLE: begin
          if (Start) begin
            byte_cnt <= '0;
            word_cnt <= '0;
          end
        end
        S_LOAD: begin
          if (din_valid && !last_byte)
            byte_cnt <= byte_cnt + ADDRA_W'(1);
        end
        S_CAPT: begin
          register2 <= register1;
          register1 <= db;
          sel_cnt   <= '0;
          // first word only primes the pair
          if (word_cnt == '0)
            word_cnt <= ADDRB_W'(1);
        end
        S_STEER: begin
          sel_cnt <= sel_cnt + 2'd1;
          if (sel_cnt == 2'd3 && !last_word)
            word_cnt <= word_cnt + ADDRB_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    din_ready = 1'b0;
    EN_A      = 1'b0;
    W_A       = 1'b0;
    Addra     = '0;
    dina      = '0;
    EN_B      = 1'b0;
    Addrb     = '0;
    En_Steer  = 1'b0;
    Select    = '0;
    LOCK      = 1'b1;
    Complete  = 1'b0;
    unique case (state)
      S_IDLE: begin
        LOCK = 1'b0;
        if (Start)
          state_nx = S_LOAD;
      end
      S_LOAD: begin
        din_ready = 1'b1;
        if (din_valid) begin
          EN_A  = 1'b1;
          W_A   = 1'b1;
          Addra = byte_cnt;
          dina  = din;
          if (last_byte)
            state_nx = S_READ;
        end
      end
      S_READ: begin
        EN_B     = 1'b1;
        Addrb    = word_cnt;
        state_nx = S_CAPT;
      end
      S_CAPT: begin
        state_nx = (word_cnt == '0) ? S_READ : S_STEER;
      end
      S_STEER: begin
        En_Steer = 1'b1;
        Select   = {1'b0, sel_cnt};
        if (sel_cnt == 2'd3)
          state_nx = last_word ? S_DONE : S_READ;
      end
      S_DONE: begin
        Complete = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bram_window_ctrl.sv
// Directed bench for bram_window_ctrl: 16-byte instance plus an 8-byte
// instance, each with a small BRAM model on its ports.
module tb_bram_window_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  din;
  logic        din_valid;
  logic        din_ready;
  logic        en_a;
  logic        w_a;
  logic [10:0] addra;
  logic [7:0]  dina;
  logic        en_b;
  logic [8:0]  addrb;
  logic [31:0] db;
  logic [31:0] register1;
  logic [31:0] register2;
  logic        en_steer;
  logic [2:0]  select;
  logic        lock;
  logic        complete;

  logic        start_m;
  logic [7:0]  din_m;
  logic        din_valid_m;
  logic        din_ready_m;
  logic        en_a_m;
  logic        w_a_m;
  logic [10:0] addra_m;
  logic [7:0]  dina_m;
  logic        en_b_m;
  logic [8:0]  addrb_m;
  logic [31:0] db_m;
  logic [31:0] register1_m;
  logic [31:0] register2_m;
  logic        en_steer_m;
  logic [2:0]  select_m;
  logic        lock_m;
  logic        complete_m;

  logic [7:0]  mem [0:15];
  logic [7:0]  mem_m [0:7];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int steer_n = 0;

  always #5 clk = ~clk;

  bram_window_ctrl #(
    .LOAD_BYTES(16),
    .ADDRA_W(11),
    .ADDRB_W(9)
  ) u_dut (
    .CLK(clk), .Reset(rst_n), .Start(start),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .EN_A(en_a), .W_A(w_a), .Addra(addra), .dina(dina),
    .EN_B(en_b), .Addrb(addrb), .db(db),
    .register1(register1), .register2(register2),
    .En_Steer(en_steer), .Select(select),
    .LOCK(lock), .Complete(complete)
  );

  bram_window_ctrl #(
    .LOAD_BYTES(8),
    .ADDRA_W(11),
    .ADDRB_W(9)
  ) u_min (
    .CLK(clk), .Reset(rst_n), .Start(start_m),
    .din(din_m), .din_valid(din_valid_m), .din_ready(din_ready_m),
    .EN_A(en_a_m), .W_A(w_a_m), .Addra(addra_m), .dina(dina_m),
    .EN_B(en_b_m), .Addrb(addrb_m), .db(db_m),
    .register1(register1_m), .register2(register2_m),
    .En_Steer(en_steer_m), .Select(select_m),
    .LOCK(lock_m), .Complete(complete_m)
  );

  always @(posedge clk) begin
    if (en_a && w_a)
      mem[addra[3:0]] <= dina;
    if (en_b)
      db <= {mem[{addrb[1:0], 2'd3}], mem[{addrb[1:0], 2'd2}],
             mem[{addrb[1:0], 2'd1}], mem[{addrb[1:0], 2'd0}]};
    if (en_a_m && w_a_m)
      mem_m[addra_m[2:0]] <= dina_m;
    if (en_b_m)
      db_m <= {mem_m[{addrb_m[0], 2'd3}], mem_m[{addrb_m[0], 2'd2}],
               mem_m[{addrb_m[0], 2'd1}], mem_m[{addrb_m[0], 2'd0}]};
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d got %h exp %h", tag, cyc, got, exp);
    end
  endtask

  task automatic quiet_all(input string tag);
    chk({tag, "_ctl"}, 32'({lock, en_steer, select, din_ready,
                            en_b, en_a, w_a, complete}), 32'd0);
    chk({tag, "_addr"}, 32'({addra, dina, addrb}), 32'd0);
    chk({tag, "_r1"}, register1, 32'd0);
    chk({tag, "_r2"}, register2, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    din = 8'h00;
    din_valid = 1'b1;
    start_m = 1'b0;
    din_m = 8'h00;
    din_valid_m = 1'b0;

    // reset with random inputs, Start high throughout
    repeat (2) begin
      @(posedge clk); #1;
      din = 8'($urandom);
      din_valid = 1'($urandom);
    end
    rst_n = 1'b1;
    start = 1'b0;
    din_valid = 1'b0;
    @(negedge clk);
    quiet_all("rst");
    chk("rst_lock_m", 32'(lock_m), 32'd0);
    chk("rst_r1_m", register1_m, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_idle", 32'(lock), 32'd0);

    // full run, continuous input
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      start = (c == 0);
      din_valid = (c >= 1 && c <= 16);
      din = 8'(c - 1);
      @(negedge clk);
      cyc = c;
      if (c >= 1 && c <= 16) begin
        chk("ld_addra", 32'(addra), 32'(c - 1));
        chk("ld_dina", 32'(dina), 32'(c - 1));
        chk("ld_en", 32'({en_a, w_a, din_ready}), 32'd7);
      end
      chk("rd_en_b", 32'(en_b), 32'(c == 17 || c == 19 || c == 25 || c == 31));
      if (c == 17) chk("rd_addrb0", 32'(addrb), 32'd0);
      if (c == 19) chk("rd_addrb1", 32'(addrb), 32'd1);
      if (c == 25) chk("rd_addrb2", 32'(addrb), 32'd2);
      if (c == 31) chk("rd_addrb3", 32'(addrb), 32'd3);
      if (c == 21) begin
        chk("st_r1", register1, 32'h07060504);
        chk("st_r2", register2, 32'h03020100);
      end
      if (c == 33) begin
        chk("st3_r1", register1, 32'h0F0E0D0C);
        chk("st3_r2", register2, 32'h0B0A0908);
      end
      if (c >= 21 && c <= 36 && ((c - 21) % 6) < 4)
        chk("steer", 32'({en_steer, select}), 32'({1'b1, 3'((c - 21) % 6)}));
      else
        chk("no_steer", 32'({en_steer, select}), 32'd0);
      chk("complete", 32'(complete), 32'(c == 37));
      chk("lock", 32'(lock), 32'(c >= 1 && c <= 37));
    end

    // gapped load, stray Starts, held Start, mid-STEER reset
    for (int c = 0; c < 83; c++) begin
      @(posedge clk); #1;
      start = (c == 0 || c == 10 || c == 38 || (c >= 50 && c <= 54) || c == 80);
      rst_n = (c != 77);
      if (c >= 1 && c <= 32) begin
        din_valid = (c % 2 == 0);
        din = 8'(8'h80 + c / 2 - 1);
      end else if (c >= 55 && c <= 70) begin
        din_valid = 1'b1;
        din = 8'(8'h40 + c - 55);
      end else begin
        din_valid = (c >= 81);
        din = 8'h11;
      end
      @(negedge clk);
      cyc = c;
      if (c >= 1 && c <= 32) begin
        chk("gap_en_a", 32'({en_a, w_a}), (c % 2 == 0) ? 32'd3 : 32'd0);
        chk("gap_ready", 32'({din_ready, lock}), 32'd3);
        if (c % 2 == 0) chk("gap_addra", 32'(addra), 32'(c / 2 - 1));
      end
      if (c == 33) chk("gap_rd0", 32'({en_b, addrb}), 32'({1'b1, 9'd0}));
      if (c == 35) chk("gap_rd1", 32'({en_b, addrb}), 32'({1'b1, 9'd1}));
      if (c == 37) begin
        chk("gap_r1", register1, 32'h87868584);
        chk("gap_r2", register2, 32'h83828180);
      end
      if (c >= 37 && c <= 40)
        chk("gap_sel", 32'({en_steer, select}), 32'({1'b1, 3'(c - 37)}));
      if (c == 41) chk("gap_rd2", 32'({en_b, addrb}), 32'({1'b1, 9'd2}));
      if (c < 77) chk("gap_cmpl", 32'(complete), 32'(c == 53));
      if (c == 54) chk("held_idle", 32'({lock, din_ready}), 32'd0);
      if (c == 55) chk("held_ld0", 32'({lock, en_a, addra}), 32'({2'b11, 11'd0}));
      if (c == 56) chk("held_ld1", 32'(addra), 32'd1);
      if (c == 77) begin
        chk("pre_sel", 32'({en_steer, select}), 32'({1'b1, 3'd2}));
        chk("pre_r1", register1, 32'h47464544);
        chk("pre_r2", register2, 32'h43424140);
      end
      if (c == 78) quiet_all("midrst");
      if (c == 81) chk("rst_ld0", 32'({lock, en_a, addra}), 32'({2'b11, 11'd0}));
      if (c == 82) chk("rst_ld1", 32'(addra), 32'd1);
    end

    // recover, then minimum-size instance
    rst_n = 1'b0;
    start = 1'b0;
    din_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 21; c++) begin
      @(posedge clk); #1;
      start_m = (c == 0);
      din_valid_m = (c >= 1 && c <= 8);
      din_m = 8'(c - 1);
      @(negedge clk);
      cyc = c;
      if (en_steer_m) steer_n++;
      if (c >= 1 && c <= 8) chk("m_addra", 32'(addra_m), 32'(c - 1));
      chk("m_steer", 32'({en_steer_m, select_m}),
          (c >= 13 && c <= 16) ? 32'({1'b1, 3'(c - 13)}) : 32'd0);
      chk("m_cmpl", 32'(complete_m), 32'(c == 17));
      if (c == 13) begin
        chk("m_r1", register1_m, 32'h07060504);
        chk("m_r2", register2_m, 32'h03020100);
      end
      if (c == 18) chk("m_lock", 32'(lock_m), 32'd0);
    end
    chk("m_steer_n", 32'(steer_n), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
